// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and the
// receive FSM state encoding.
package uart_pkg;

   localparam int DATA_BITS            = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 217;   // 25 MHz / 115200 baud

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO. The head entry is always visible on data_out, so the
// storage is read combinationally. A push into a full FIFO is accepted only
// when a pop happens on the same edge.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [DATA_BITS-1:0] data_in,
   output logic                 full,
   input  logic                 pop,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 empty,
   output logic [CNT_W-1:0]     count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 wr_en;
   logic                 rd_en;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);

   // Head byte is forced to zero while empty so the output is clean at reset.
   assign data_out = empty ? '0 : mem[rd_ptr];

   // Storage write; contents need no reset because empty masks the output.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= data_in;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with mid-bit sampling, stop-bit framing check and a
// show-ahead receive FIFO drained by a valid/ready handshake.
module uart_rx_buffered
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_n,
   input  logic                 i_RX_Serial,
   output logic [DATA_BITS-1:0] o_RX_Byte,
   output logic                 o_RX_Valid,
   input  logic                 i_RX_Ready,
   output logic                 o_Frame_Err,
   output logic                 o_Overrun,
   output logic                 o_RX_Busy,
   output logic [CNT_W-1:0]     o_Fifo_Count
);

   localparam int CW    = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CW-1:0]    MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0]    LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   logic                 rx_meta;
   logic                 rx_s;
   rx_state_t            state, state_next;
   logic [CW-1:0]        clk_cnt, clk_cnt_next;
   logic [IDX_W-1:0]     bit_idx, bit_idx_next;
   logic [DATA_BITS-1:0] shift, shift_next;
   logic                 push_pend, push_next;
   logic                 frame_err, frame_err_next;
   logic                 overrun;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;

   // Two-flop synchroniser; resets to the idle (high) line level.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_RX_Serial;
         rx_s    <= rx_meta;
      end
   end

   // FSM, bit timing and the registered push / framing-error strobes.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         push_pend <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_next;
         clk_cnt   <= clk_cnt_next;
         bit_idx   <= bit_idx_next;
         shift     <= shift_next;
         push_pend <= push_next;
         frame_err <= frame_err_next;
      end
   end

   // Next-state logic: count to mid start bit, then a full bit per sample.
   always_comb begin
      state_next     = state;
      clk_cnt_next   = clk_cnt + CW'(1);
      bit_idx_next   = bit_idx;
      shift_next     = shift;
      push_next      = 1'b0;
      frame_err_next = 1'b0;
      case (state)
         IDLE: begin
            clk_cnt_next = '0;
            if (!rx_s) begin
               state_next = START;
            end
         end
         START: begin
            if (clk_cnt == MID_CNT) begin
               clk_cnt_next = '0;
               if (!rx_s) begin
                  state_next   = DATA;
                  bit_idx_next = '0;
               end else begin
                  state_next = IDLE;   // start bit did not survive: glitch
               end
            end
         end
         DATA: begin
            if (clk_cnt == LAST_CNT) begin
               clk_cnt_next        = '0;
               shift_next[bit_idx] = rx_s;
               if (bit_idx == LAST_IDX) begin
                  state_next = STOP;
               end else begin
                  bit_idx_next = bit_idx + IDX_W'(1);
               end
            end
         end
         STOP: begin
            if (clk_cnt == LAST_CNT) begin
               clk_cnt_next = '0;
               state_next   = IDLE;    // re-arm mid stop bit
               if (rx_s) begin
                  push_next = 1'b1;
               end else begin
                  frame_err_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign pop = ~fifo_empty & i_RX_Ready;

   // A byte is lost only when the FIFO is full and nothing drains this edge.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         overrun <= 1'b0;
      end else begin
         overrun <= push_pend & fifo_full & ~pop;
      end
   end

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk      (i_Clock),
      .rst_n    (i_Rst_n),
      .push     (push_pend),
      .data_in  (shift),
      .full     (fifo_full),
      .pop      (pop),
      .data_out (o_RX_Byte),
      .empty    (fifo_empty),
      .count    (o_Fifo_Count)
   );

   assign o_RX_Valid  = ~fifo_empty;
   assign o_Frame_Err = frame_err;
   assign o_Overrun   = overrun;
   assign o_RX_Busy   = (state != IDLE);

endmodule
